// File: rtl/cfg_scan_loader_pkg.sv
// Shared types and helpers for the configuration scan-chain loader.
package cozy_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_WORD,
      SHIFT_LO,
      SHIFT_HI,
      FINISH
   } state_t;

   // One connection-block channel: two ROMs of two bits each.
   localparam int BITS_PER_CB = 4;

   function automatic int words_for(input int len, input int w);
      return (len + w - 1) / w;
   endfunction

endpackage

// File: rtl/cfg_scan_loader_if.sv
// Valid/ready configuration word channel between controller and scan loader.
interface cfg_scan_loader_if #(parameter int WORD_W = 8);

   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/cfg_scan_loader_word_shifter.sv
// Parallel-load, shift-left word register with a down-counting bit counter.
module cfg_word_shifter #(
   parameter int W     = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [W-1:0]     load_data,
   input  logic [CNT_W-1:0] load_cnt,
   input  logic             shift,
   input  logic             shift_in,
   output logic [W-1:0]     data,
   output logic [CNT_W-1:0] cnt
);

   logic [W-1:0]     data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load wins over shift so a new word never merges with stale bits.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load) begin
         data_d = load_data;
         cnt_d  = load_cnt;
      end else if (shift) begin
         data_d = {data_q[W-2:0], shift_in};
         cnt_d  = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data = data_q;
   assign cnt  = cnt_q;

endmodule

// File: rtl/cfg_scan_loader.sv
// Serialises configuration words into the fabric scan chain at clk/2 and
// returns the displaced chain contents as readback words.
module cfg_scan_loader
   import cozy_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 4,
   parameter int WORD_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   cfg_scan_loader_if.slave  cfg,
   output logic              scan_clk,
   output logic              scan_en,
   output logic              scan_in,
   input  logic              scan_ret,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam int TOT_W = $clog2(CHAIN_LEN + 1);

   state_t             state_q, state_d;
   logic [TOT_W-1:0]   bit_total_q, bit_total_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic               scan_clk_q, scan_clk_d;
   logic               scan_en_q, scan_en_d;
   logic               scan_in_q, scan_in_d;
   logic [WORD_W-1:0]  rb_data_q, rb_data_d;
   logic               rb_valid_q, rb_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               tx_load, tx_shift, rx_shift;
   logic [CNT_W-1:0]   word_bits;
   logic [WORD_W-1:0]  tx_data, rx_data;
   logic [CNT_W-1:0]   tx_cnt, rx_cnt;

   // The transmit register holds only the bits queued behind scan_in, so the
   // word's MSB goes straight to scan_in and the rest is pre-shifted by one.
   cfg_word_shifter #(.W(WORD_W), .CNT_W(CNT_W)) u_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tx_load),
      .load_data ({cfg.cfg_data[WORD_W-2:0], 1'b0}),
      .load_cnt  (word_bits),
      .shift     (tx_shift),
      .shift_in  (1'b0),
      .data      (tx_data),
      .cnt       (tx_cnt)
   );

   // Readback counts down from a full word; the residue is the left-align amount.
   cfg_word_shifter #(.W(WORD_W), .CNT_W(CNT_W)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tx_load),
      .load_data ('0),
      .load_cnt  (CNT_W'(WORD_W)),
      .shift     (rx_shift),
      .shift_in  (scan_ret),
      .data      (rx_data),
      .cnt       (rx_cnt)
   );

   always_comb begin
      state_d     = state_q;
      bit_total_d = bit_total_q;
      tx_load     = 1'b0;
      tx_shift    = 1'b0;
      rx_shift    = 1'b0;
      rb_valid_d  = 1'b0;
      rb_data_d   = rb_data_q;
      word_bits   = CNT_W'(WORD_W);
      if (int'(bit_total_q) < WORD_W) word_bits = CNT_W'(bit_total_q);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = WAIT_WORD;
               bit_total_d = TOT_W'(CHAIN_LEN);
            end
         end
         WAIT_WORD: begin
            if (cfg.cfg_valid) begin
               tx_load = 1'b1;
               state_d = SHIFT_LO;
            end
         end
         // scan_ret is sampled on the edge that raises scan_clk, before the chain moves.
         SHIFT_LO: begin
            rx_shift = 1'b1;
            state_d  = SHIFT_HI;
         end
         SHIFT_HI: begin
            tx_shift    = 1'b1;
            bit_total_d = bit_total_q - TOT_W'(1);
            if (tx_cnt == CNT_W'(1)) begin
               rb_valid_d = 1'b1;
               rb_data_d  = rx_data << rx_cnt;
            end
            if (bit_total_q == TOT_W'(1))   state_d = FINISH;
            else if (tx_cnt == CNT_W'(1))   state_d = WAIT_WORD;
            else                            state_d = SHIFT_LO;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cfg_ready_d = (state_d == WAIT_WORD);
      scan_clk_d  = (state_d == SHIFT_HI);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == FINISH);
      scan_en_d   = 1'b0;
      scan_in_d   = 1'b0;
      case (state_d)
         WAIT_WORD: scan_en_d = scan_en_q;
         SHIFT_LO: begin
            scan_en_d = 1'b1;
            scan_in_d = tx_load ? cfg.cfg_data[WORD_W-1] : tx_data[WORD_W-1];
         end
         SHIFT_HI: begin
            scan_en_d = 1'b1;
            scan_in_d = scan_in_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_total_q <= '0;
         cfg_ready_q <= 1'b0;
         scan_clk_q  <= 1'b0;
         scan_en_q   <= 1'b0;
         scan_in_q   <= 1'b0;
         rb_data_q   <= '0;
         rb_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_total_q <= bit_total_d;
         cfg_ready_q <= cfg_ready_d;
         scan_clk_q  <= scan_clk_d;
         scan_en_q   <= scan_en_d;
         scan_in_q   <= scan_in_d;
         rb_data_q   <= rb_data_d;
         rb_valid_q  <= rb_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;
   assign scan_clk      = scan_clk_q;
   assign scan_en       = scan_en_q;
   assign scan_in       = scan_in_q;
   assign rb_data       = rb_data_q;
   assign rb_valid      = rb_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
